// File: rtl/binary_to_bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package binary_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Decimal digits of 2^bin_w - 1. 2^b is never a power of ten, so this is
  // floor(b*log10(2)) + 1; log10(2) is held as a 12-digit fixed-point constant.
  function automatic int min_digits(input int bin_w);
    longint scaled;
    scaled = longint'(bin_w) * 64'sd301029995664;
    return int'(scaled / 64'sd1000000000000) + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one operand bit per clock,
// with optional two's-complement input and valid/ready handshakes on both sides.
module binary_to_bcd_seq
  import binary_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg_out
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  if (BIN_W < 2) begin : g_bad_bin_w
    $error("binary_to_bcd_seq: BIN_W must be at least 2");
  end

  if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $error("binary_to_bcd_seq: DIGITS too small for BIN_W");
  end

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WORK_W-1:0]   work_q;    // {BCD digits, remaining magnitude bits}
  logic                neg_q;

  logic [BIN_W-1:0]    mag_in;
  logic                sign_in;
  logic [BCD_W-1:0]    bcd_adj;
  logic                accept;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    sign_in = 1'b0;
    mag_in  = bin_in;
    // The most negative input negates to itself, which read unsigned is the right magnitude.
    if (SIGNED && bin_in[BIN_W-1]) begin
      sign_in = 1'b1;
      mag_in  = -bin_in;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (work_q[BIN_W + 4*g +: 4]),
      .adj   (bcd_adj[4*g +: 4])
    );
  end

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      neg_q   <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      state_q <= SHIFT;
      cnt_q   <= CNT_W'(BIN_W);
      work_q  <= {{BCD_W{1'b0}}, mag_in};
      neg_q   <= sign_in;
    end else begin
      case (state_q)
        SHIFT: begin
          // The adjusted top bit is always 0 when DIGITS is large enough, so truncation is safe.
          work_q <= WORK_W'({bcd_adj, work_q[BIN_W-1:0], 1'b0});
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE:    if (out_ready) state_q <= IDLE;
        IDLE:    ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign bcd_out   = work_q[WORK_W-1 -: BCD_W];
  assign neg_out   = neg_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Self-checking bench: three converter configurations sharing a clock, a tagged
// scoreboard queue filled on input handshakes and drained on output handshakes.
module tb_binary_to_bcd_seq;

  typedef struct packed {
    logic [1:0]  dut;
    logic [19:0] bcd;
    logic        neg;
  } exp_t;

  typedef struct {
    int          dut;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        neg;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv   [3];
  logic        ordy [3];
  logic [15:0] bin  [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [19:0] bcd  [3];
  logic        neg  [3];

  logic        ir0, ov0, neg0, ir1, ov1, neg1, ir2, ov2, neg2;
  logic [11:0] bcd0, bcd1;
  logic [19:0] bcd2;

  binary_to_bcd_seq u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .bin_in(bin[0][7:0]),
    .out_valid(ov0), .out_ready(ordy[0]), .bcd_out(bcd0), .neg_out(neg0)
  );

  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .bin_in(bin[1][7:0]),
    .out_valid(ov1), .out_ready(ordy[1]), .bcd_out(bcd1), .neg_out(neg1)
  );

  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .bin_in(bin[2]),
    .out_valid(ov2), .out_ready(ordy[2]), .bcd_out(bcd2), .neg_out(neg2)
  );

  assign ir[0] = ir0;  assign ov[0] = ov0;  assign neg[0] = neg0;  assign bcd[0] = {8'd0, bcd0};
  assign ir[1] = ir1;  assign ov[1] = ov1;  assign neg[1] = neg1;  assign bcd[1] = {8'd0, bcd1};
  assign ir[2] = ir2;  assign ov[2] = ov2;  assign neg[2] = neg2;  assign bcd[2] = bcd2;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb [$];
  exp_t pend [3];
  bit   sweep_on = 1'b0;
  int   last_pop = -1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion by repeated division, independent of the shift-add method.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Handshakes are observed at the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && ordy[d]) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result dut%0d: got bcd 0x%0h, expected no result", d, bcd[d]);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("result_owner dut%0d", d), 32'(d), 32'(e.dut));
            check($sformatf("bcd_out dut%0d", d), 32'(bcd[d]), 32'(e.bcd));
            check($sformatf("neg_out dut%0d", d), 32'(neg[d]), 32'(e.neg));
            if (sweep_on && d == 0) begin
              if (last_pop >= 0) check("out_valid_spacing", 32'(cyc - last_pop), 32'd9);
              last_pop = cyc;
            end
          end
        end
      end
      for (int d = 0; d < 3; d++)
        if (iv[d] && ir[d]) sb.push_back(pend[d]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand, wait for acceptance, then count edges until out_valid rises.
  task automatic send(input int d, input logic [15:0] v, input logic [19:0] eb,
                      input logic en, output int lat);
    bit acc;
    acc = 1'b0;
    iv[d]   = 1'b1;
    bin[d]  = v;
    pend[d] = '{dut: 2'(d), bcd: eb, neg: en};
    for (int k = 0; k < 200 && !acc; k++) begin
      if (ir[d]) acc = 1'b1;
      step();
    end
    iv[d] = 1'b0;
    check($sformatf("accepted dut%0d", d), 32'(acc), 32'd1);
    lat = 0;
    while (!ov[d] && lat < 100) begin
      step();
      lat++;
    end
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() > 0; k++) step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    step();
  endtask

  vec_t vecs [10];
  int   lat;

  initial begin
    vecs[0] = '{0, 16'd255,   20'h00255, 1'b0, 8};
    vecs[1] = '{0, 16'd0,     20'h00000, 1'b0, 8};
    vecs[2] = '{0, 16'd99,    20'h00099, 1'b0, 8};
    vecs[3] = '{0, 16'd100,   20'h00100, 1'b0, 8};
    vecs[4] = '{1, 16'h0080,  20'h00128, 1'b1, 8};
    vecs[5] = '{1, 16'h00FF,  20'h00001, 1'b1, 8};
    vecs[6] = '{1, 16'h007F,  20'h00127, 1'b0, 8};
    vecs[7] = '{1, 16'h0000,  20'h00000, 1'b0, 8};
    vecs[8] = '{2, 16'd65535, 20'h65535, 1'b0, 16};
    vecs[9] = '{2, 16'd40000, 20'h40000, 1'b0, 16};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; bin[d] = '0; pend[d] = '0;
    end
    repeat (3) step();
    check("reset in_ready",  32'(ir[0]),  32'd1);
    check("reset out_valid", 32'(ov[0]),  32'd0);
    check("reset bcd_out",   32'(bcd[0]), 32'd0);
    check("reset neg_out",   32'(neg[0]), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].dut, vecs[i].bin, vecs[i].bcd, vecs[i].neg, lat);
      check($sformatf("latency vec%0d", i), 32'(lat), 32'(vecs[i].lat));
      drain();
    end

    // Exhaustive sweep with in_valid held: every result after the first is back-to-back.
    sweep_on = 1'b1;
    iv[0] = 1'b1;
    for (int v = 0; v < 256; v++) begin
      bit acc;
      acc = 1'b0;
      bin[0]  = 16'(v);
      pend[0] = '{dut: 2'd0, bcd: to_bcd(v), neg: 1'b0};
      for (int k = 0; k < 50 && !acc; k++) begin
        if (ir[0]) acc = 1'b1;
        step();
      end
      if (!acc) check($sformatf("sweep accept %0d", v), 32'(acc), 32'd1);
    end
    iv[0] = 1'b0;
    drain();
    sweep_on = 1'b0;

    // Backpressure: result held for 20 cycles, pending operand refused until release.
    ordy[0] = 1'b0;
    send(0, 16'd200, 20'h00200, 1'b0, lat);
    check("bp latency", 32'(lat), 32'd8);
    iv[0]   = 1'b1;
    bin[0]  = 16'd55;
    pend[0] = '{dut: 2'd0, bcd: 20'h00055, neg: 1'b0};
    for (int k = 0; k < 20; k++) begin
      check("bp bcd_out held",  32'(bcd[0]), 32'h200);
      check("bp out_valid held", 32'(ov[0]), 32'd1);
      check("bp in_ready low",  32'(ir[0]),  32'd0);
      step();
    end
    ordy[0] = 1'b1;
    #1;
    check("bp in_ready follows out_ready", 32'(ir[0]), 32'd1);
    step();
    iv[0] = 1'b0;
    check("bp out_valid after take",   32'(ov[0]), 32'd0);
    check("bp new operand in flight",  32'(ir[0]), 32'd0);
    drain();

    // Asynchronous reset during the fourth SHIFT cycle discards the conversion.
    iv[0]   = 1'b1;
    bin[0]  = 16'd255;
    pend[0] = '{dut: 2'd0, bcd: 20'h00255, neg: 1'b0};
    step();
    iv[0] = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(ov[0]),  32'd0);
    check("abort in_ready",  32'(ir[0]),  32'd1);
    check("abort bcd_out",   32'(bcd[0]), 32'd0);
    sb.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    send(0, 16'd37, 20'h00037, 1'b0, lat);
    check("post-abort latency", 32'(lat), 32'd8);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
